immediate_encoder: RTL and testbench

//  Inverse of the immediate zero-extension path: takes a 16-bit value and finds the

---
 rtl/immediate_encoder_pkg.sv | 39 +++
 rtl/immediate_range_check.sv | 48 ++++
 rtl/immediate_encoder.sv | 109 ++++++++++
 tb/tb_immediate_encoder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/immediate_encoder_pkg.sv
// Purpose: shared ImmdLocation codes, field widths and field-selection helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package immediate_encoder_pkg;

    // ImmdLocation codes, shared with the immediate zero extender
    localparam logic [1:0] LOC_5B  = 2'b00;
    localparam logic [1:0] LOC_8B  = 2'b01;
    localparam logic [1:0] LOC_11B = 2'b10;
    localparam logic [1:0] LOC_1B  = 2'b11;

    // Immediate field widths in bits
    localparam int W_1B  = 1;
    localparam int W_5B  = 5;
    localparam int W_8B  = 8;
    localparam int W_11B = 11;

    // One flag per field: value is exactly representable in that field
    typedef struct packed {
        logic fit_1b;
        logic fit_5b;
        logic fit_8b;
        logic fit_11b;
    } range_t;

    // Narrowest field wins; unencodable values fall back to the 11-bit code
    function automatic logic [1:0] select_loc(input range_t r);
        if (r.fit_1b)      return LOC_1B;
        else if (r.fit_5b) return LOC_5B;
        else if (r.fit_8b) return LOC_8B;
        else               return LOC_11B;
    endfunction

    // Any field fitting means the value is encodable
    function automatic logic select_fits(input range_t r);
        return |r;
    endfunction

endpackage

// File: rtl/immediate_range_check.sv
// Purpose: combinational per-field range compares on a raw value (unsigned, or signed when SIGN_EXT_EN).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller registers the result.
module immediate_range_check
    import immediate_encoder_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] value,
`ifdef SIGN_EXT_EN
    input  logic              is_signed,
`endif
    output range_t            rng
);

    range_t uns_rng;

    // Unsigned fit: every bit above the field width is zero
    always_comb begin
        uns_rng.fit_1b  = ~|value[DATA_W-1:W_1B];
        uns_rng.fit_5b  = ~|value[DATA_W-1:W_5B];
        uns_rng.fit_8b  = ~|value[DATA_W-1:W_8B];
        uns_rng.fit_11b = ~|value[DATA_W-1:W_11B];
    end

`ifdef SIGN_EXT_EN
    range_t sgn_rng;

    // Signed fit: the field's sign bit and everything above it all agree
    always_comb begin
        sgn_rng.fit_1b  = (&value) | (~|value);
        sgn_rng.fit_5b  = (&value[DATA_W-1:W_5B-1])  | (~|value[DATA_W-1:W_5B-1]);
        sgn_rng.fit_8b  = (&value[DATA_W-1:W_8B-1])  | (~|value[DATA_W-1:W_8B-1]);
        sgn_rng.fit_11b = (&value[DATA_W-1:W_11B-1]) | (~|value[DATA_W-1:W_11B-1]);
    end

    // Pick the interpretation requested for this value
    always_comb begin
        rng = is_signed ? sgn_rng : uns_rng;
    end
`else
    // Only unsigned ranges exist in this build
    always_comb begin
        rng = uns_rng;
    end
`endif

endmodule

// File: rtl/immediate_encoder.sv
// Purpose: find the narrowest immediate field (1/5/8/11b) holding a value; optional SIGN_EXT_EN adds in_signed.
// Latency: 2 cycles accept->out_valid, full throughput of one value per cycle.
// Backpressure: valid/ready; in_ready drops only when both stages are full and out_ready is low.
module immediate_encoder
    import immediate_encoder_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
`ifdef SIGN_EXT_EN
    input  logic              in_signed,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_field,
    output logic [1:0]        out_loc,
    output logic              out_fits,
    output logic [CNT_W-1:0]  miss_count
);

    localparam logic [CNT_W-1:0] MISS_MAX = '1;

    // Stage 1 keeps only the bits any field can carry plus the compare results
    typedef struct packed {
        logic [W_11B-1:0] low;
        range_t           rng;
    } s1_dat_t;

    s1_dat_t           s1_dat;
    logic              s1_vld;
    logic              s2_vld;
    logic              s2_load;
    logic              s1_adv;
    logic              in_accept;
    range_t            rng_nxt;
    logic [DATA_W-1:0] field_nxt;
    logic [1:0]        loc_nxt;
    logic              fits_nxt;

    immediate_range_check #(
        .DATA_W (DATA_W)
    ) u_range_check (
        .value     (in_value),
`ifdef SIGN_EXT_EN
        .is_signed (in_signed),
`endif
        .rng       (rng_nxt)
    );

    assign s2_load   = !s2_vld || out_ready;
    assign s1_adv    = s1_vld && s2_load;
    assign in_ready  = !s1_vld || s1_adv;
    assign in_accept = in_valid && in_ready;
    assign out_valid = s2_vld;

    // Stage-2 selection: code from the first matching range, field truncated and zero-padded
    always_comb begin
        loc_nxt   = select_loc(s1_dat.rng);
        fits_nxt  = select_fits(s1_dat.rng);
        field_nxt = '0;
        case (loc_nxt)
            LOC_1B:  field_nxt[W_1B-1:0]  = s1_dat.low[W_1B-1:0];
            LOC_5B:  field_nxt[W_5B-1:0]  = s1_dat.low[W_5B-1:0];
            LOC_8B:  field_nxt[W_8B-1:0]  = s1_dat.low[W_8B-1:0];
            default: field_nxt[W_11B-1:0] = s1_dat.low[W_11B-1:0];
        endcase
    end

    // Stage 1: capture accepted value and its range flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else if (in_accept) begin
            s1_vld     <= 1'b1;
            s1_dat.low <= in_value[W_11B-1:0];
            s1_dat.rng <= rng_nxt;
        end else if (s1_adv) begin
            s1_vld <= 1'b0;
        end
    end

    // Stage 2: output register, held while stalled; counts unencodable values as they land
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_vld     <= 1'b0;
            out_field  <= '0;
            out_loc    <= LOC_5B;
            out_fits   <= 1'b0;
            miss_count <= '0;
        end else if (s2_load) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                out_field <= field_nxt;
                out_loc   <= loc_nxt;
                out_fits  <= fits_nxt;
                if (!fits_nxt && (miss_count != MISS_MAX)) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_immediate_encoder.sv
// Purpose: self-checking bench for immediate_encoder (table vectors, scoreboard, corner sequences).
// Latency: checks 2-cycle accept->out_valid and one result per cycle when unstalled.
// Backpressure: exercises out_ready stalls, random out_ready and mid-stream reset.
module tb_immediate_encoder;

    localparam int TB_CNT_W = 4;
    localparam int MISS_MAX = (1 << TB_CNT_W) - 1;

    typedef struct {
        logic [15:0] value;
        logic        sgn;
        logic [15:0] field;
        logic [1:0]  loc;
        logic        fits;
    } sb_t;

    typedef struct {
        logic [15:0] value;
        logic [15:0] field;
        logic [1:0]  loc;
        logic        fits;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [15:0]         in_value;
`ifdef SIGN_EXT_EN
    logic                in_signed;
`endif
    logic                out_valid;
    logic                out_ready;
    logic [15:0]         out_field;
    logic [1:0]          out_loc;
    logic                out_fits;
    logic [TB_CNT_W-1:0] miss_count;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   prev_pop = -1;
    int   last_wait = 0;
    int   model_miss = 0;
    bit   gap_chk = 0;
    bit   rand_rdy = 0;
    bit   accepted = 0;
    sb_t  drv_exp;
    sb_t  sb[$];
    vec_t tbl[11];

    always #5 clk = ~clk;

    immediate_encoder #(
        .DATA_W (16),
        .CNT_W  (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
`ifdef SIGN_EXT_EN
        .in_signed  (in_signed),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_field  (out_field),
        .out_loc    (out_loc),
        .out_fits   (out_fits),
        .miss_count (miss_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic sb_t model(input logic [15:0] v, input logic s);
        sb_t r;
        int  sv;
        r.value = v;
        r.sgn   = s;
        r.fits  = 1'b1;
        sv      = int'($signed(v));
        if (!s) begin
            if (v < 16'd2)         begin r.loc = 2'b11; r.field = {15'b0, v[0]};   end
            else if (v < 16'd32)   begin r.loc = 2'b00; r.field = {11'b0, v[4:0]}; end
            else if (v < 16'd256)  begin r.loc = 2'b01; r.field = {8'b0, v[7:0]};  end
            else if (v < 16'd2048) begin r.loc = 2'b10; r.field = {5'b0, v[10:0]}; end
            else begin r.loc = 2'b10; r.field = {5'b0, v[10:0]}; r.fits = 1'b0; end
        end else begin
            if (sv == 0 || sv == -1)              begin r.loc = 2'b11; r.field = {15'b0, v[0]};   end
            else if (sv >= -16 && sv <= 15)       begin r.loc = 2'b00; r.field = {11'b0, v[4:0]}; end
            else if (sv >= -128 && sv <= 127)     begin r.loc = 2'b01; r.field = {8'b0, v[7:0]};  end
            else if (sv >= -1024 && sv <= 1023)   begin r.loc = 2'b10; r.field = {5'b0, v[10:0]}; end
            else begin r.loc = 2'b10; r.field = {5'b0, v[10:0]}; r.fits = 1'b0; end
        end
        return r;
    endfunction

    // Zero extender as the instruction decoder would apply it
    function automatic logic [15:0] zext(input logic [15:0] f, input logic [1:0] loc);
        case (loc)
            2'b11:   return {15'b0, f[0]};
            2'b00:   return {11'b0, f[4:0]};
            2'b01:   return {8'b0, f[7:0]};
            default: return {5'b0, f[10:0]};
        endcase
    endfunction

    // One clock: monitor/scoreboard at negedge, then step past the rising edge
    task automatic tick();
        sb_t e;
        @(negedge clk);
        cyc++;
        accepted = 0;
        if (rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got field 0x%0h with nothing expected (cycle %0d)", out_field, cyc);
                end else begin
                    e = sb.pop_front();
                    if (!e.fits && model_miss < MISS_MAX) model_miss++;
                    chk("field", 32'(out_field), 32'(e.field));
                    chk("loc", 32'(out_loc), 32'(e.loc));
                    chk("fits", 32'(out_fits), 32'(e.fits));
                    chk("miss_count", 32'(miss_count), 32'(model_miss));
                    if (e.fits && !e.sgn) chk("roundtrip", 32'(zext(out_field, out_loc)), 32'(e.value));
                    if (gap_chk && prev_pop >= 0) chk("bubble", 32'(cyc - prev_pop), 32'd1);
                    prev_pop = cyc;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(drv_exp);
                accepted = 1;
            end
        end
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(input sb_t e);
        int n;
        in_valid = 1'b1;
        in_value = e.value;
`ifdef SIGN_EXT_EN
        in_signed = e.sgn;
`endif
        drv_exp = e;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 64);
        last_wait = n;
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL drive_timeout: value 0x%0h not accepted within %0d cycles", e.value, n);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        sb_t e;
        int  k;
        tbl[0]  = '{16'h0000, 16'h0000, 2'b11, 1'b1};
        tbl[1]  = '{16'h0001, 16'h0001, 2'b11, 1'b1};
        tbl[2]  = '{16'h0002, 16'h0002, 2'b00, 1'b1};
        tbl[3]  = '{16'h001F, 16'h001F, 2'b00, 1'b1};
        tbl[4]  = '{16'h0020, 16'h0020, 2'b01, 1'b1};
        tbl[5]  = '{16'h00FF, 16'h00FF, 2'b01, 1'b1};
        tbl[6]  = '{16'h07FF, 16'h07FF, 2'b10, 1'b1};
        tbl[7]  = '{16'h0800, 16'h0000, 2'b10, 1'b0};
        tbl[8]  = '{16'h0100, 16'h0100, 2'b10, 1'b1};
        tbl[9]  = '{16'h1234, 16'h0234, 2'b10, 1'b0};
        tbl[10] = '{16'hFFFF, 16'h07FF, 2'b10, 1'b0};

        rst = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        out_ready = 1'b0;
`ifdef SIGN_EXT_EN
        in_signed = 1'b0;
`endif
        @(posedge clk);
        #1;

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_field", 32'(out_field), 32'd0);
        chk("rst_loc", 32'(out_loc), 32'd0);
        chk("rst_fits", 32'(out_fits), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();

        // Single value: 2-cycle latency
        drive(model(16'h0001, 1'b0));
        chk("lat_s1_only", 32'(out_valid), 32'd0);
        tick();
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        drain();

        // Table stream, back to back, no stalls and no output bubbles
        gap_chk = 1;
        prev_pop = -1;
        for (int i = 0; i < 11; i++) begin
            e.value = tbl[i].value;
            e.sgn   = 1'b0;
            e.field = tbl[i].field;
            e.loc   = tbl[i].loc;
            e.fits  = tbl[i].fits;
            drive(e);
            chk("stream_stall", 32'(last_wait), 32'd1);
        end
        drain();
        gap_chk = 0;

        // Backpressure: two accepts fill the pipe, outputs hold while stalled
        out_ready = 1'b0;
        drive(model(16'h0003, 1'b0));
        drive(model(16'h0456, 1'b0));
        in_valid = 1'b1;
        in_value = 16'h00A5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_field", 32'(out_field), 32'(sb[0].field));
            chk("bp_hold_loc", 32'(out_loc), 32'(sb[0].loc));
        end
        out_ready = 1'b1;
        drive(model(16'h00A5, 1'b0));
        drain();

        // Reset with two misses in flight: nothing survives
        out_ready = 1'b0;
        drive(model(16'h0800, 1'b0));
        drive(model(16'h1000, 1'b0));
        chk("pre_rst_miss", 32'(miss_count), 32'(model_miss + 1));
        rst = 1'b0;
        tick();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_miss", 32'(miss_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        model_miss = 0;
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Saturation of the miss counter
        for (int i = 0; i < MISS_MAX + 3; i++) begin
            drive(model(16'h0800 + 16'(i * 256), 1'b0));
        end
        drain();
        chk("miss_saturated", 32'(miss_count), 32'(MISS_MAX));

        // Randomised values and out_ready
        rand_rdy = 1;
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 16));
            drive(model(16'($urandom_range(0, (1 << k) - 1)), 1'b0));
        end
        rand_rdy = 0;
        out_ready = 1'b1;
        drain();

`ifdef SIGN_EXT_EN
        // Signed ranges
        drive(model(16'hFFFF, 1'b1));
        drive(model(16'hFFF0, 1'b1));
        drive(model(16'hFC00, 1'b1));
        drive(model(16'hFBFF, 1'b1));
        drive(model(16'h0001, 1'b1));
        drive(model(16'h0001, 1'b0));
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
